// File: rtl/dac_sample_sched.sv
// dac_sample_sched: per-period duty-cycle fetch from CPU handshake or FIFO, applied at PWM period wrap.
// On FIFO underrun the last duty cycle is held, or midscale is output instead, and the event is counted.
module dac_sample_sched #(
    parameter int WIDTH         = 12,
    parameter int PERIOD        = 4096,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dac_source,
    input  logic             req,
    input  logic [WIDTH-1:0] rv_duty_cycle,
    output logic             ack,
    input  logic             fifo_empty,
    output logic             fifo_r_en,
    input  logic [WIDTH-1:0] fifo_r_data,
    input  logic             clr_underrun,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             period_start,
    output logic             underrun,
    output logic [15:0]      underrun_count
);
    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] P4 = CW'(PERIOD - 4);
    localparam logic [CW-1:0] P3 = CW'(PERIOD - 3);
    localparam logic [CW-1:0] P1 = CW'(PERIOD - 1);
    localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              src_q, rd_q, ur_q;
    logic [WIDTH-1:0]  staged, cpu_pending;
    logic              ur_evt;

    assign ur_evt = (state == FETCH) && ur_q;

    // The source/read decision is registered one cycle early so the read strobe is
    // high while cnt==PERIOD-3 and its data lands in time for FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            src_q          <= 1'b0;
            rd_q           <= 1'b0;
            ur_q           <= 1'b0;
            staged         <= '0;
            cpu_pending    <= '0;
            ack            <= 1'b0;
            fifo_r_en      <= 1'b0;
            duty_cycle     <= '0;
            period_start   <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            cnt          <= cnt == P1 ? '0 : cnt + 1'b1;
            period_start <= cnt == P1;
            fifo_r_en    <= 1'b0;
            underrun     <= 1'b0;
            if (req && !ack) begin
                cpu_pending <= rv_duty_cycle;
                ack         <= 1'b1;
            end else if (!req && ack) begin
                ack <= 1'b0;
            end
            if (clr_underrun)
                underrun_count <= {15'b0, ur_evt};
            else if (ur_evt && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
            case (state)
                IDLE: begin
                    if (cnt == P4) begin
                        src_q     <= dac_source;
                        fifo_r_en <= dac_source && !fifo_empty;
                        rd_q      <= dac_source && !fifo_empty;
                        ur_q      <= dac_source && fifo_empty;
                    end
                    if (cnt == P3) begin
                        if (!src_q)
                            staged <= cpu_pending;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_q)
                        staged <= fifo_r_data;
                    if (ur_q) begin
                        staged   <= UNDERRUN_HOLD != 0 ? duty_cycle : MID;
                        underrun <= 1'b1;
                    end
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    duty_cycle <= staged;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched: directed table plus hand sequences for dac_sample_sched with PERIOD=8.
// u_a holds the last sample on underrun, u_b outputs midscale; both see the same FIFO and CPU inputs.
module tb_dac_sample_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dac_source = 1'b1;
    logic        req = 1'b0;
    logic [11:0] rv_duty_cycle = '0;
    logic        clr_underrun = 1'b0;
    logic        fifo_empty;
    logic [11:0] fifo_r_data = '0;
    logic        ack_a, ren_a, ps_a, ur_a, ack_b, ren_b, ps_b, ur_b;
    logic [11:0] duty_a, duty_b;
    logic [15:0] cnt_a, cnt_b;
    logic [11:0] q[$];
    int          n = 0;
    int          checks = 0;
    int          failures = 0;
    int          ren_total = 0;
    int          bad_ren = 0;

    always #5 clk = ~clk;

    dac_sample_sched #(.WIDTH(12), .PERIOD(8), .UNDERRUN_HOLD(1)) u_a (
        .clk(clk), .rst(rst), .dac_source(dac_source), .req(req), .rv_duty_cycle(rv_duty_cycle),
        .ack(ack_a), .fifo_empty(fifo_empty), .fifo_r_en(ren_a), .fifo_r_data(fifo_r_data),
        .clr_underrun(clr_underrun), .duty_cycle(duty_a), .period_start(ps_a), .underrun(ur_a),
        .underrun_count(cnt_a));

    dac_sample_sched #(.WIDTH(12), .PERIOD(8), .UNDERRUN_HOLD(0)) u_b (
        .clk(clk), .rst(rst), .dac_source(dac_source), .req(req), .rv_duty_cycle(rv_duty_cycle),
        .ack(ack_b), .fifo_empty(fifo_empty), .fifo_r_en(ren_b), .fifo_r_data(fifo_r_data),
        .clr_underrun(clr_underrun), .duty_cycle(duty_b), .period_start(ps_b), .underrun(ur_b),
        .underrun_count(cnt_b));

    assign fifo_empty = q.size() == 0;

    always @(posedge clk)
        if (ren_a && q.size() > 0)
            fifo_r_data <= q.pop_front();

    // Reference period position: clock edges since reset release.
    always @(posedge clk or posedge rst)
        n <= rst ? 0 : n + 1;

    always @(negedge clk)
        if (!rst && ren_a) begin
            ren_total++;
            if (n % 8 != 5)
                bad_ren++;
        end

    typedef struct {
        int          n;
        logic [11:0] da, db;
        logic        ps, ren, ur;
        logic [15:0] cnt;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (n=%0d)", nm, act, exp, n);
        end
    endtask

    task automatic run_to(input int k);
        while (n < k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (n=%0d)", n);
        $fatal(1);
    end

    initial begin
        v[0]  = '{0,  12'h000, 12'h000, 0, 0, 0, 16'd0};
        v[1]  = '{5,  12'h000, 12'h000, 0, 1, 0, 16'd0};
        v[2]  = '{6,  12'h000, 12'h000, 0, 0, 0, 16'd0};
        v[3]  = '{8,  12'h100, 12'h100, 1, 0, 0, 16'd0};
        v[4]  = '{9,  12'h100, 12'h100, 0, 0, 0, 16'd0};
        v[5]  = '{13, 12'h100, 12'h100, 0, 1, 0, 16'd0};
        v[6]  = '{16, 12'h200, 12'h200, 1, 0, 0, 16'd0};
        v[7]  = '{21, 12'h200, 12'h200, 0, 0, 0, 16'd0};
        v[8]  = '{23, 12'h200, 12'h200, 0, 0, 1, 16'd1};
        v[9]  = '{24, 12'h200, 12'h800, 1, 0, 0, 16'd1};
        v[10] = '{31, 12'h200, 12'h800, 0, 0, 1, 16'd2};
        v[11] = '{32, 12'h200, 12'h800, 1, 0, 0, 16'd2};
        v[12] = '{39, 12'h200, 12'h800, 0, 0, 1, 16'd3};
        v[13] = '{40, 12'h200, 12'h800, 1, 0, 0, 16'd3};

        q.push_back(12'h100);
        q.push_back(12'h200);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            run_to(v[i].n);
            chk($sformatf("fifo_vec%0d", i), {duty_a, duty_b, ps_a, ren_a, ur_a, cnt_a},
                {v[i].da, v[i].db, v[i].ps, v[i].ren, v[i].ur, v[i].cnt});
        end

        // CPU handshake source
        rst = 1'b1;
        dac_source = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ren_total = 0;
        chk("cpu_reset_state", {duty_a, ack_a, cnt_a}, 29'h0);
        run_to(1);
        req = 1'b1;
        rv_duty_cycle = 12'h3FF;
        run_to(2);
        chk("cpu_ack_rise", ack_a, 1);
        run_to(7);
        chk("cpu_duty_before_wrap", duty_a, 12'h000);
        run_to(8);
        chk("cpu_duty_at_wrap", {duty_a, ps_a}, {12'h3FF, 1'b1});
        run_to(9);
        chk("cpu_ack_held", ack_a, 1);
        req = 1'b0;
        run_to(10);
        chk("cpu_ack_fall", ack_a, 0);
        q.push_back(12'h555);
        run_to(16);
        chk("cpu_no_fifo_read", ren_total, 0);

        // Source switch mid-period takes effect at the next decision only
        run_to(18);
        dac_source = 1'b1;
        run_to(21);
        chk("switch_read", ren_a, 1);
        run_to(22);
        chk("switch_no_glitch", duty_a, 12'h3FF);
        run_to(24);
        chk("switch_duty", duty_a, 12'h555);
        chk("switch_one_read", ren_total, 1);

        // Underrun counter saturation and clear-with-underrun
        run_to(25);
        force u_a.underrun_count = 16'hFFFE;
        #1 release u_a.underrun_count;
        run_to(31);
        chk("sat_1", {ur_a, cnt_a}, {1'b1, 16'hFFFF});
        run_to(39);
        chk("sat_2", cnt_a, 16'hFFFF);
        run_to(47);
        chk("sat_3", cnt_a, 16'hFFFF);
        run_to(54);
        clr_underrun = 1'b1;
        run_to(55);
        clr_underrun = 1'b0;
        chk("clr_with_underrun", {ur_a, cnt_a}, {1'b1, 16'd1});

        // Asynchronous reset right after a FIFO read
        q.push_back(12'hABC);
        q.push_back(12'hDEF);
        run_to(61);
        chk("pre_reset_read", ren_a, 1);
        run_to(62);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", {duty_a, ps_a, ren_a, ur_a, cnt_a, ack_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_to(4);
        chk("restart_no_early_read", ren_a, 0);
        run_to(5);
        chk("restart_read", ren_a, 1);
        run_to(7);
        chk("restart_no_stale", duty_a, 12'h000);
        run_to(8);
        chk("restart_new_sample", {duty_a, ps_a, cnt_a}, {12'hDEF, 1'b1, 16'd0});
        chk("reads_only_at_decision", bad_ren, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
